alu_seq_exec: RTL and testbench
===============================

// Module: alu_seq_exec
// PURPOSE
//  Parametrised sequential ALU execute unit; successor to the single-function
//  combinational ALU slices (pass-A/pass-B, add, logic). Merges the slices
//  behind one opcode, registers the result and adds multi-cycle iterative
//  shifts (1 bit/cycle) under a start/busy/done handshake. Sits in the
//  execute stage between the operand muxes and writeback.
// PARAMETERS
//  N    8               datapath width; power of 2, >= 2
//  SHW  $clog2(N)       localparam, shift-amount width; shamt = B[SHW-1:0]
// PORTS
//  clk     in   1  rising-edge clock
//  rst_n   in   1  asynchronous active-low reset
//  start   in   1  request; sampled only when busy=0
//  op      in   4  opcode, sampled with start
//  A       in   N  operand A, sampled with start
//  B       in   N  operand B / shift amount, sampled with start
//  busy    out  1  high while a shift is in progress
//  done    out  1  one-cycle completion pulse
//  result  out  N  registered result; holds until next completion
//  zero    out  1  result == 0, updated with result
//  carry   out  1  carry/shift-out flag, updated with result
// BEHAVIOUR
//  Reset: busy=0, done=0, result=0, zero=0, carry=0, FSM=IDLE, counter=0.
//  Reset during SHIFT aborts the operation; no done pulse is issued.
//  Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SELA (A), 6 SELB (B),
//   8 SLL, 9 SRL, 10 SRA; others -> result=0, carry=0, single-cycle.
//  FSM IDLE: start=1 and single-cycle op -> result/flags loaded at that
//   edge, done=1 next cycle, remain IDLE. Latency 1.
//  IDLE, shift op, shamt=0 -> treated as single-cycle: result=A, carry=0.
//  IDLE, shift op, shamt=k>0 -> acc=A, cnt=k, busy=1, go SHIFT.
//  SHIFT: each edge shifts acc by 1 (SLL fill 0, SRL fill 0, SRA fill
//   acc[N-1]), cnt-=1, tracks bit shifted out. At the edge where cnt==1:
//   result=shifted acc, carry=last bit out, busy=0, done=1, go IDLE.
//   Latency k+1 cycles start->done; busy high exactly k cycles.
//  ADD: {carry,result}=A+B. SUB: result=A-B, carry=1 iff A>=B unsigned
//   (carry of A+~B+1). Logic/select ops: carry=0. All wrap modulo 2^N.
//  zero computed from the new result value, same edge as result.
//  done is high for exactly one cycle per accepted request; start during
//   busy=1 is ignored (no queue, no error). start in the cycle done=1
//   (busy=0) is accepted normally; back-to-back single-cycle ops give
//   done high on consecutive cycles.
//  Operands are captured at acceptance; changes to A/B/op during SHIFT
//   have no effect.
// TESTING (N=8)
//  ADD A=0xF0 B=0x20 -> next cycle done=1, result=0x10, carry=1, zero=0
//  SELB A=0x12 B=0xAB -> latency 1, result=0xAB, carry=0; SELA -> 0x12
//  SUB A=0x5A B=0x5A -> result=0x00, zero=1, carry=1; A=0x01 B=0x02 ->
//   result=0xFF, carry=0
//  SLL A=0x81 B=0x03 -> busy 3 cycles, done at cycle 4, result=0x08,
//   carry=0; SRA A=0x80 B=0x03 -> 0xF0; SRL A=0x81 B=0x01 -> 0x40, carry=1
//  SRL A=0xFF B=0x07 with start re-pulsed (op=ADD) mid-shift -> ignored;
//   single done, result=0x01; shift with B=0x08 (shamt=0) -> result=A, L=1
//  rst_n low during SLL B=0x05 -> all outputs 0 immediately, no done;
//   new ADD after release completes normally

Source files
------------

// File: rtl/alu_seq_exec.sv
// Sequential ALU execute unit: single-cycle arithmetic/logic ops plus
// iterative 1-bit-per-cycle shifts behind a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; single-cycle ops complete from here
// SHIFT | shifting acc_q one bit per cycle until cnt_q reaches 1
module alu_seq_exec #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         carry
);

    localparam int SHW = $clog2(N);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SELA = 4'd5;
    localparam logic [3:0] OP_SELB = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;

    localparam logic [1:0] SH_SLL = 2'd0;
    localparam logic [1:0] SH_SRL = 2'd1;
    localparam logic [1:0] SH_SRA = 2'd2;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [SHW-1:0] cnt_q, cnt_d;
    logic [1:0]     sop_q, sop_d;
    logic [N-1:0]   result_q, result_d;
    logic           carry_q, carry_d;
    logic           zero_q, zero_d;
    logic           done_q, done_d;

    logic [N-1:0]   alu_res;
    logic           alu_c;
    logic [N:0]     sum;
    logic           is_shift;
    logic [1:0]     sop_in;
    logic [SHW-1:0] shamt;
    logic [N-1:0]   acc_sh;
    logic           bit_out;

    assign shamt = B[SHW-1:0];

    // Single-cycle datapath; SUB carry is the carry-out of A + ~B + 1.
    always_comb begin
        alu_res  = '0;
        alu_c    = 1'b0;
        sum      = '0;
        is_shift = 1'b0;
        sop_in   = SH_SLL;
        case (op)
            OP_ADD: begin
                sum     = {1'b0, A} + {1'b0, B};
                alu_res = sum[N-1:0];
                alu_c   = sum[N];
            end
            OP_SUB: begin
                sum     = {1'b0, A} + {1'b0, ~B} + {{N{1'b0}}, 1'b1};
                alu_res = sum[N-1:0];
                alu_c   = sum[N];
            end
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_SELA: alu_res = A;
            OP_SELB: alu_res = B;
            OP_SLL: begin
                is_shift = 1'b1;
                sop_in   = SH_SLL;
            end
            OP_SRL: begin
                is_shift = 1'b1;
                sop_in   = SH_SRL;
            end
            OP_SRA: begin
                is_shift = 1'b1;
                sop_in   = SH_SRA;
            end
            default: begin
                alu_res = '0;
                alu_c   = 1'b0;
            end
        endcase
    end

    always_comb begin
        acc_sh  = acc_q;
        bit_out = 1'b0;
        case (sop_q)
            SH_SLL: begin
                acc_sh  = {acc_q[N-2:0], 1'b0};
                bit_out = acc_q[N-1];
            end
            SH_SRL: begin
                acc_sh  = {1'b0, acc_q[N-1:1]};
                bit_out = acc_q[0];
            end
            SH_SRA: begin
                acc_sh  = {acc_q[N-1], acc_q[N-1:1]};
                bit_out = acc_q[0];
            end
            default: begin
                acc_sh  = acc_q;
                bit_out = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sop_d    = sop_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_shift && (shamt != '0)) begin
                        acc_d   = A;
                        cnt_d   = shamt;
                        sop_d   = sop_in;
                        state_d = SHIFT;
                    end else begin
                        // A zero-distance shift degenerates to a pass of A.
                        result_d = is_shift ? A : alu_res;
                        carry_d  = is_shift ? 1'b0 : alu_c;
                        zero_d   = is_shift ? (A == '0) : (alu_res == '0);
                        done_d   = 1'b1;
                    end
                end
            end
            SHIFT: begin
                acc_d = acc_sh;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    result_d = acc_sh;
                    carry_d  = bit_out;
                    zero_d   = (acc_sh == '0);
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            sop_q    <= SH_SLL;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sop_q    <= sop_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == SHIFT);
    assign done   = done_q;
    assign result = result_q;
    assign zero   = zero_q;
    assign carry  = carry_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Scoreboard bench for alu_seq_exec: stimulus pushes expected completions,
// an independent monitor pops and checks them whenever done is seen.
module tb_alu_seq_exec;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] op;
    logic [7:0] A;
    logic [7:0] B;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       zero;
    logic       carry;

    alu_seq_exec #(.N(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero),
        .carry  (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] res;
        logic       c;
        logic       z;
        int         due;
        int         k;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: plain integer arithmetic straight from the opcode rules.
    function automatic exp_t model(input logic [3:0] o, input logic [7:0] a,
                                   input logic [7:0] b, input int now, input string nm);
        exp_t e;
        int ai = int'(a);
        int bi = int'(b);
        int k  = bi % 8;
        e.res = 8'h00; e.c = 1'b0; e.k = 0; e.name = nm;
        case (o)
            4'd0: begin e.res = 8'(ai + bi); e.c = (ai + bi) > 255; end
            4'd1: begin e.res = 8'(ai - bi); e.c = (ai >= bi); end
            4'd2: e.res = a & b;
            4'd3: e.res = a | b;
            4'd4: e.res = a ^ b;
            4'd5: e.res = a;
            4'd6: e.res = b;
            4'd8, 4'd9, 4'd10: begin
                if (k == 0) e.res = a;
                else begin
                    e.k = k;
                    if (o == 4'd8) begin
                        e.res = 8'(ai << k);
                        e.c   = ((ai >> (8 - k)) & 1) != 0;
                    end else begin
                        if (o == 4'd9) e.res = 8'(ai >> k);
                        else           e.res = 8'($signed(a) >>> k);
                        e.c = ((ai >> (k - 1)) & 1) != 0;
                    end
                end
            end
            default: begin e.res = 8'h00; e.c = 1'b0; end
        endcase
        e.z   = (e.res == 8'h00);
        e.due = now + 1 + e.k;
        return e;
    endfunction

    // Monitor: independent of stimulus, driven only by DUT outputs.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, "_result"}, int'(result), int'(e.res));
                    check({e.name, "_carry"}, int'(carry), int'(e.c));
                    check({e.name, "_zero"}, int'(zero), int'(e.z));
                    check({e.name, "_latency"}, cyc, e.due);
                    check({e.name, "_busy_cycles"}, busy_cnt, e.k);
                end
                busy_cnt = 0;
            end
            if (busy) busy_cnt++;
        end
    end

    task automatic send(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                        input string nm);
        int guard = 0;
        while (busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check({nm, "_busy_timeout"}, 1, 0);
        start = 1'b1; op = o; A = a; B = b;
        sb.push_back(model(o, a, b, cyc, nm));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string nm);
        int guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check({nm, "_drain_left"}, sb.size(), 0);
        sb.delete();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 4'h0; A = 8'h00; B = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_result", int'(result), 0);
        check("rst_zero", int'(zero), 0);
        check("rst_carry", int'(carry), 0);
        rst_n = 1'b1;
        @(negedge clk);

        send(4'd0, 8'hF0, 8'h20, "add_ovf");
        send(4'd6, 8'h12, 8'hAB, "selb");
        send(4'd5, 8'h12, 8'hAB, "sela");
        send(4'd1, 8'h5A, 8'h5A, "sub_eq");
        send(4'd1, 8'h01, 8'h02, "sub_borrow");
        send(4'd8, 8'h81, 8'h03, "sll3");
        send(4'd10, 8'h80, 8'h03, "sra3");
        send(4'd9, 8'h81, 8'h01, "srl1");
        send(4'd8, 8'h5C, 8'h08, "sll_shamt0");
        send(4'd7, 8'h33, 8'h44, "undef_op");
        drain("directed");

        // Re-pulsed start and changing operands while busy must be ignored.
        send(4'd9, 8'hFF, 8'h07, "srl7_ignore");
        for (int i = 0; i < 4; i++) begin
            start = 1'b1; op = 4'd0; A = 8'(i * 17); B = 8'h55;
            @(negedge clk);
        end
        start = 1'b0;
        drain("ignore");

        // Reset in the middle of a shift aborts it with no done pulse.
        send(4'd8, 8'h81, 8'h05, "sll5_abort");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_result", int'(result), 0);
        check("abort_zero", int'(zero), 0);
        check("abort_carry", int'(carry), 0);
        repeat (8) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(4'd0, 8'h11, 8'h22, "add_after_rst");
        drain("post_reset");

        for (int i = 0; i < 60; i++) begin
            logic [3:0] o;
            o = 4'($urandom_range(0, 15));
            send(o, 8'($urandom), 8'($urandom), $sformatf("rand%0d_op%0d", i, o));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
